// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: shared instruction-type encoding and store-FSM state enum for the retirement engine.
package commit_unit_pkg;
  typedef enum logic [3:0] {
    IT_ALU    = 4'd0,
    IT_LOAD   = 4'd1,
    IT_STORE  = 4'd2,
    IT_BRANCH = 4'd3,
    IT_JUMP   = 4'd4
  } itype_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_POP
  } store_state_e;
endpackage

// File: rtl/commit_unit_store_writer.sv
// store_writer: store FSM driving the memory request/ack handshake and the one-cycle ROB pop pulse.
module store_writer
  import commit_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              store_valid_in,
  input  logic [ADDR_W-3:0] word_addr_in,
  input  logic [31:0]       data_in,
  input  logic              mem_ready_in,
  input  logic              mem_ack_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_data_out,
  output logic              pop_out,
  output logic              busy_out
);
  store_state_e state, state_nx;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state        <= ST_IDLE;
      mem_addr_out <= '0;
      mem_data_out <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && store_valid_in) begin
        mem_addr_out <= {word_addr_in, 2'b00};
        mem_data_out <= data_in;
      end
    end
  // REQ only looks at ready, so an ack arriving alongside acceptance is dropped
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     state_nx = store_valid_in ? ST_REQ : ST_IDLE;
      ST_REQ:      state_nx = mem_ready_in ? ST_WAIT_ACK : ST_REQ;
      ST_WAIT_ACK: state_nx = mem_ack_in ? ST_POP : ST_WAIT_ACK;
      default:     state_nx = ST_IDLE;
    endcase
  end
  assign mem_req_out = state == ST_REQ;
  assign pop_out     = state == ST_POP;
  assign busy_out    = state != ST_IDLE;
endmodule

// File: rtl/commit_unit.sv
// commit_unit: ROB-head retirement engine; register-file writes plus committed stores to memory.
// Optional COMMIT_STATS_EN adds commit_count_out/store_count_out retirement counters.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int RF_IX_W = 5
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rob_commit_in,
  input  logic               rob_store_valid_in,
  input  logic [2:0]         rob_ix_in,
  input  logic [3:0]         rob_itype_in,
  input  logic [31:0]        rob_value_in,
  input  logic [31:0]        rob_dest_in,
  output logic               rob_store_read_out,
  output logic               rf_we_out,
  output logic [RF_IX_W-1:0] rf_addr_out,
  output logic [31:0]        rf_data_out,
  output logic               mem_req_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  output logic [31:0]        mem_data_out,
  input  logic               mem_ready_in,
  input  logic               mem_ack_in,
  output logic               busy_out
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]        commit_count_out,
  output logic [31:0]        store_count_out
`endif
);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      rf_we_out   <= 1'b0;
      rf_addr_out <= '0;
      rf_data_out <= '0;
    end else begin
      rf_we_out <= rob_commit_in && rob_dest_in[RF_IX_W-1:0] != '0;
      if (rob_commit_in) begin
        rf_addr_out <= rob_dest_in[RF_IX_W-1:0];
        rf_data_out <= rob_value_in;
      end
    end
  store_writer #(.ADDR_W(ADDR_W)) u_store (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .store_valid_in(rob_store_valid_in),
    .word_addr_in  (rob_dest_in[ADDR_W-1:2]),
    .data_in       (rob_value_in),
    .mem_ready_in  (mem_ready_in),
    .mem_ack_in    (mem_ack_in),
    .mem_req_out   (mem_req_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_out  (mem_data_out),
    .pop_out       (rob_store_read_out),
    .busy_out      (busy_out)
  );
`ifdef COMMIT_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      commit_count_out <= '0;
      store_count_out  <= '0;
    end else begin
      commit_count_out <= commit_count_out + 32'(rob_commit_in) + 32'(rob_store_read_out);
      store_count_out  <= store_count_out + 32'(rob_store_read_out);
    end
`endif
  // both strobes describe the same head entry, so they can never legally coincide
  assert property (@(posedge clk_in) disable iff (!rst_n_in) !(rob_commit_in && rob_store_valid_in));
  assert property (@(posedge clk_in) disable iff (!rst_n_in)
    rob_store_valid_in |-> (rob_itype_in == IT_STORE) && !$isunknown(rob_ix_in));
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed bench with a ROB-head driver, a memory responder and a spec-level output model.
module tb_commit_unit;
  import commit_unit_pkg::*;
  logic clk_in = 1'b0, rst_n_in = 1'b0;
  logic rob_commit_in = 0, rob_store_valid_in = 0;
  logic [2:0] rob_ix_in = '0;
  logic [3:0] rob_itype_in = '0;
  logic [31:0] rob_value_in = '0, rob_dest_in = '0;
  logic rob_store_read_out, rf_we_out, mem_req_out, busy_out;
  logic [4:0] rf_addr_out;
  logic [31:0] rf_data_out, mem_addr_out, mem_data_out;
  logic mem_ready_in = 0, mem_ack_in = 0;
`ifdef COMMIT_STATS_EN
  logic [31:0] commit_count_out, store_count_out;
`endif

  commit_unit dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .rob_commit_in(rob_commit_in), .rob_store_valid_in(rob_store_valid_in),
    .rob_ix_in(rob_ix_in), .rob_itype_in(rob_itype_in),
    .rob_value_in(rob_value_in), .rob_dest_in(rob_dest_in),
    .rob_store_read_out(rob_store_read_out),
    .rf_we_out(rf_we_out), .rf_addr_out(rf_addr_out), .rf_data_out(rf_data_out),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_ready_in(mem_ready_in), .mem_ack_in(mem_ack_in),
    .busy_out(busy_out)
`ifdef COMMIT_STATS_EN
    , .commit_count_out(commit_count_out), .store_count_out(store_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {bit st; logic [31:0] dest; logic [31:0] val;} ent_t;
  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  ent_t rq[$];
  wr_t wq[$];

  int total = 0, bad = 0;
  int cyc = 0, valid_cyc = 0, pop_cyc = 0;
  int npop = 0, nwr = 0, nacc = 0;
  int rw = 0, pend = 0, req_len = 0, last_req_len = 0;
  int rdy_lat = 0, ack_lat = 1;
  bit tie = 0, waiting = 0, pop_due = 0, pop_seen = 0, prev_hold = 0;
  logic [31:0] prev_a = '0, prev_d = '0, acc_a = '0, acc_d = '0, wr_d = '0;
  logic [4:0] wr_a = '0;
  logic m_we = 0;
  logic [4:0] m_addr = '0;
  logic [31:0] m_data = '0, m_cc = '0, m_sc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit st, input logic [31:0] dest, input logic [31:0] val);
    rq.push_back('{st: st, dest: dest, val: val});
    if (st) wq.push_back({dest & 32'hFFFF_FFFC, val});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic wait_pops(input int n, input string nm);
    int k = 0;
    while (npop < n && k < 200) begin
      idle(1);
      k++;
    end
    chk(nm, 32'(npop >= n), 1);
  endtask

  // ROB head: a commit head leaves at the edge it is seen; a store head waits for the pop pulse
  initial begin : drv
    bit pv;
    forever begin
      @(posedge clk_in);
      #2;
      if (rq.size() > 0 && (rob_commit_in || (rob_store_valid_in && pop_seen))) begin
        rq.delete(0);
        rob_ix_in = rob_ix_in + 3'd1;
      end
      pv = rob_store_valid_in;
      if (rq.size() == 0) begin
        rob_commit_in = 0;
        rob_store_valid_in = 0;
        rob_dest_in = '0;
        rob_value_in = '0;
        rob_itype_in = IT_ALU;
      end else begin
        rob_commit_in = !rq[0].st;
        rob_store_valid_in = rq[0].st;
        rob_dest_in = rq[0].dest;
        rob_value_in = rq[0].val;
        rob_itype_in = rq[0].st ? IT_STORE : IT_ALU;
      end
      if (!pv && rob_store_valid_in) valid_cyc = cyc + 1;
    end
  end

  // per-cycle compare against the spec model, then memory responder for the coming edge
  initial begin : mon
    wr_t ew;
    forever begin
      @(negedge clk_in);
      cyc++;
      pop_seen = rob_store_read_out;
      if (!rst_n_in) begin
        m_we = 0; m_addr = '0; m_data = '0; m_cc = '0; m_sc = '0;
        pop_due = 0; waiting = 0; pend = 0; rw = 0; req_len = 0; prev_hold = 0;
        mem_ready_in = 0; mem_ack_in = 0;
      end
      chk("rf_we", rf_we_out, m_we);
      chk("rf_addr", rf_addr_out, m_addr);
      chk("rf_data", rf_data_out, m_data);
      chk("pop_pulse", rob_store_read_out, pop_due);
      if (waiting) begin
        chk("req_in_wait", mem_req_out, 0);
        chk("busy_in_wait", busy_out, 1);
      end
`ifdef COMMIT_STATS_EN
      chk("commit_count", commit_count_out, m_cc);
      chk("store_count", store_count_out, m_sc);
`endif
      if (rst_n_in) begin
        if (rob_store_read_out) begin
          npop++;
          pop_cyc = cyc;
        end
        if (rf_we_out) begin
          nwr++;
          wr_a = rf_addr_out;
          wr_d = rf_data_out;
        end
        m_we = rob_commit_in && rob_dest_in[4:0] != 5'd0;
        if (rob_commit_in) begin
          m_addr = rob_dest_in[4:0];
          m_data = rob_value_in;
        end
        m_cc = m_cc + 32'(rob_commit_in) + 32'(rob_store_read_out);
        m_sc = m_sc + 32'(rob_store_read_out);
        pop_due = 0; mem_ack_in = 0; mem_ready_in = 0;
        if (waiting) begin
          if (!tie) pend--;
          if (tie || pend == 0) begin
            mem_ack_in = 1;
            waiting = 0;
            pop_due = 1;
          end
        end
        if (tie) begin
          mem_ready_in = 1;
          mem_ack_in = 1;
        end
        if (prev_hold && mem_req_out) begin
          chk("hold_addr", mem_addr_out, prev_a);
          chk("hold_data", mem_data_out, prev_d);
        end
        if (mem_req_out) begin
          req_len++;
          if (tie || rw >= rdy_lat) begin
            mem_ready_in = 1;
            nacc++;
            acc_a = mem_addr_out;
            acc_d = mem_data_out;
            ew = wq.size() > 0 ? wq.pop_front() : 'x;
            chk("write_addr", mem_addr_out, ew.a);
            chk("write_data", mem_data_out, ew.d);
            last_req_len = req_len;
            req_len = 0; rw = 0; waiting = 1; pend = ack_lat;
          end else rw++;
        end
        prev_hold = mem_req_out && !mem_ready_in;
        prev_a = mem_addr_out;
        prev_d = mem_data_out;
      end
    end
  end

  initial begin : main
    int k;
    repeat (2) @(posedge clk_in);
    #2 rst_n_in = 1;
    idle(1);
    chk("reset_rf_we", rf_we_out, 0);
    chk("reset_req", mem_req_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_addr", mem_addr_out, 0);
    chk("reset_pop", rob_store_read_out, 0);
    push(0, 32'd7, 32'hDEAD_BEEF);
    idle(4);
    chk("commit_writes", nwr, 1);
    chk("commit_addr", wr_a, 7);
    chk("commit_data", wr_d, 32'hDEAD_BEEF);
    push(0, 32'd0, 32'd5);
    idle(4);
    chk("x0_no_write", nwr, 1);
    tie = 1;
    push(1, 32'h1003, 32'h55);
    wait_pops(1, "store1_pop");
    chk("store1_addr", acc_a, 32'h1000);
    chk("store1_data", acc_d, 32'h55);
    chk("store1_latency", pop_cyc - valid_cyc, 3);
    idle(3);
    chk("store1_single_pop", npop, 1);
    tie = 0; rdy_lat = 5; ack_lat = 4;
    push(1, 32'h2000, 32'hA5A5);
    wait_pops(2, "bp_pop");
    chk("bp_req_len", last_req_len, 6);
    chk("bp_addr", acc_a, 32'h2000);
    idle(4);
    chk("bp_single_pop", npop, 2);
    rdy_lat = 1; ack_lat = 2;
    push(1, 32'h20, 32'd1);
    push(1, 32'h24, 32'd2);
    wait_pops(4, "pair_pops");
    idle(6);
    chk("pair_writes", nacc, 4);
    chk("pair_pops_exact", npop, 4);
    chk("pair_last_addr", acc_a, 32'h24);
    chk("pair_last_data", acc_d, 32'd2);
`ifdef COMMIT_STATS_EN
    chk("stats_commit", commit_count_out, 6);
    chk("stats_store", store_count_out, 4);
`endif
    rdy_lat = 0; ack_lat = 30;
    push(1, 32'h40, 32'h77);
    k = 0;
    while (nacc < 5 && k < 50) begin
      idle(1);
      k++;
    end
    chk("rst_store_accepted", nacc, 5);
    idle(2);
    chk("pre_rst_busy", busy_out, 1);
    chk("pre_rst_req", mem_req_out, 0);
    rst_n_in = 0;
    #1;
    chk("rst_req", mem_req_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_pop", rob_store_read_out, 0);
`ifdef COMMIT_STATS_EN
    chk("rst_commit_count", commit_count_out, 0);
    chk("rst_store_count", store_count_out, 0);
`endif
    rq.delete();
    wq.delete();
    idle(2);
    @(posedge clk_in);
    #2 rst_n_in = 1;
    idle(4);
    chk("no_pop_after_rst", npop, 4);
    push(0, 32'd3, 32'd9);
    idle(4);
    chk("post_rst_writes", nwr, 2);
    chk("post_rst_addr", wr_a, 3);
    chk("post_rst_data", wr_d, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
